// File: rtl/potential_decay_if.sv
// Timestep bundle between the neuron loop controller/adder and the decay unit.
// Master drives the adder result and timestep pulse; slave returns the decayed potential.
interface potential_decay_if;
  logic        clear;
  logic [31:0] final_potential;
  logic        spike;
  logic [1:0]  decay_shift;
  logic [31:0] decayed_potential;
  logic        decay_done;
  logic        busy;
  logic        in_refractory;
  logic        fp_error;

  modport master (
    output clear, final_potential, spike, decay_shift,
    input  decayed_potential, decay_done, busy, in_refractory, fp_error
  );

  modport slave (
    input  clear, final_potential, spike, decay_shift,
    output decayed_potential, decay_done, busy, in_refractory, fp_error
  );
endinterface

// File: rtl/potential_decay_unit.sv
// Leaky return path: scales the latched potential by 2^-shift via exponent decrements, with spike reset and refractory hold.
// Latency clear->decay_done is 2+shift cycles; no backpressure, a new clear aborts the op in flight.
module potential_decay_unit #(
  parameter logic [31:0] V_REST     = 32'h0000_0000,
  parameter logic [3:0]  REFRACTORY = 4'd2
) (
  input logic              CLK,
  input logic              RESET_N,
  potential_decay_if.slave pd
);

  typedef enum logic [1:0] {IDLE, LATCH, DECAY, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] work, work_nxt;
  logic        lat_spike, lat_spike_nxt;
  logic [1:0]  lat_shift, lat_shift_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [3:0]  refr_cnt, refr_cnt_nxt;
  logic        fp_err, fp_err_nxt;
  logic [31:0] dec_pot, dec_pot_nxt;
  logic [7:0]  exp_dec;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      work      <= V_REST;
      lat_spike <= 1'b0;
      lat_shift <= 2'd0;
      cnt       <= 2'd0;
      refr_cnt  <= 4'd0;
      fp_err    <= 1'b0;
      dec_pot   <= V_REST;
    end else begin
      state     <= state_nxt;
      work      <= work_nxt;
      lat_spike <= lat_spike_nxt;
      lat_shift <= lat_shift_nxt;
      cnt       <= cnt_nxt;
      refr_cnt  <= refr_cnt_nxt;
      fp_err    <= fp_err_nxt;
      dec_pot   <= dec_pot_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    work_nxt      = work;
    lat_spike_nxt = lat_spike;
    lat_shift_nxt = lat_shift;
    cnt_nxt       = cnt;
    refr_cnt_nxt  = refr_cnt;
    fp_err_nxt    = fp_err;
    dec_pot_nxt   = dec_pot;
    exp_dec       = work[30:23] - 8'd1;

    case (state)
      LATCH: begin
        state_nxt = DONE;
        if (lat_spike) begin
          work_nxt     = V_REST;
          refr_cnt_nxt = REFRACTORY;
        end else if (refr_cnt != 4'd0) begin
          work_nxt     = V_REST;
          refr_cnt_nxt = refr_cnt - 4'd1;
        end else if (work[30:23] == 8'hFF) begin
          work_nxt   = V_REST;
          fp_err_nxt = 1'b1;
        end else if (work[30:23] == 8'h00) begin
          work_nxt = 32'h0000_0000;
        end else if (lat_shift != 2'd0) begin
          cnt_nxt   = lat_shift;
          state_nxt = DECAY;
        end
      end
      DECAY: begin
        cnt_nxt = cnt - 2'd1;
        // Underflow to exponent 0 flushes to +0 and stops the remaining steps.
        if (exp_dec == 8'h00) begin
          work_nxt  = 32'h0000_0000;
          state_nxt = DONE;
        end else begin
          work_nxt = {work[31], exp_dec, work[22:0]};
          if (cnt == 2'd1) state_nxt = DONE;
        end
      end
      DONE: begin
        dec_pot_nxt = work;
        state_nxt   = IDLE;
      end
      default: ;
    endcase

    // A new timestep pulse always wins; refractory/error updates of an aborted LATCH stand.
    if (pd.clear) begin
      work_nxt      = pd.final_potential;
      lat_spike_nxt = pd.spike;
      lat_shift_nxt = pd.decay_shift;
      state_nxt     = LATCH;
      dec_pot_nxt   = dec_pot;
    end
  end

  assign pd.decayed_potential = dec_pot;
  assign pd.decay_done        = (state == DONE) && !pd.clear;
  assign pd.busy              = (state == LATCH) || (state == DECAY);
  assign pd.in_refractory     = (refr_cnt != 4'd0);
  assign pd.fp_error          = fp_err;

endmodule
